// File: rtl/alu_arbiter_if.sv
// Signal bundle between the two ALU requesters, the arbiter and the shared ALU.
// The arbiter connects through the slave modport. The master modport is the
// environment side: it drives the requests and the ALU's registered result.
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
);
    // Requester 0 (execute stage)
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [OPW-1:0]   op0;
    // Requester 1 (address/branch helper)
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [OPW-1:0]   op1;
    // Completion / status back to the requesters
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             err;
    logic             busy;
    // Shared ALU port
    logic [WIDTH-1:0] alu_in1;
    logic [WIDTH-1:0] alu_in2;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;

    modport slave (
        input  req0, a0, b0, op0,
        input  req1, a1, b1, op1,
        input  alu_out, alu_zero,
        output done0, done1, result, zero, err, busy,
        output alu_in1, alu_in2, alu_op
    );

    modport master (
        output req0, a0, b0, op0,
        output req1, a1, b1, op1,
        output alu_out, alu_zero,
        input  done0, done1, result, zero, err, busy,
        input  alu_in1, alu_in2, alu_op
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one registered ALU between two requesters.
// Each operation runs through four phases: grant and latch the ALU inputs,
// let the ALU register its result, capture the result, then pulse done.
// An illegal opcode skips the ALU and completes straight away with err set.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic        clk,
    input  logic        rst,
    alu_arbiter_if.slave bus
);
    // Highest opcode the ALU implements; anything above it is rejected.
    localparam logic [OPW-1:0] LAST_LEGAL_OP = OPW'(6);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_gnt;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_alu_in1;
    logic [WIDTH-1:0] r_alu_in2;
    logic [OPW-1:0]   r_alu_op;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_err;

    logic             w_any_req;
    logic             w_winner;
    logic             w_grant;
    logic             w_illegal;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [OPW-1:0]   w_sel_op;

    // Round-robin pick: a lone request wins outright; on a tie the requester
    // that was not served last time wins.
    always_comb begin
        w_winner = 1'b0;
        if (bus.req0 && bus.req1) begin
            w_winner = ~r_last_grant;
        end else if (bus.req1) begin
            w_winner = 1'b1;
        end
    end

    assign w_any_req = bus.req0 | bus.req1;
    assign w_sel_a   = w_winner ? bus.a1  : bus.a0;
    assign w_sel_b   = w_winner ? bus.b1  : bus.b0;
    assign w_sel_op  = w_winner ? bus.op1 : bus.op0;
    assign w_illegal = (w_sel_op > LAST_LEGAL_OP);

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; requests are only looked at while idle.
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_grant      = 1'b1;
                    w_state_next = w_illegal ? S_DONE : S_EXEC;
                end
            end
            S_EXEC:  w_state_next = S_WAIT;
            S_WAIT:  w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Grant bookkeeping, ALU input latching and result capture.
    // The ALU inputs are only reloaded for a legal grant, so an illegal
    // request leaves the previous operation on the ALU port untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt        <= 1'b0;
            r_last_grant <= 1'b1;
            r_alu_in1    <= '0;
            r_alu_in2    <= '0;
            r_alu_op     <= '0;
            r_result     <= '0;
            r_zero       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_grant) begin
                r_gnt        <= w_winner;
                r_last_grant <= w_winner;
                if (w_illegal) begin
                    r_result <= '0;
                    r_zero   <= 1'b0;
                    r_err    <= 1'b1;
                end else begin
                    r_alu_in1 <= w_sel_a;
                    r_alu_in2 <= w_sel_b;
                    r_alu_op  <= w_sel_op;
                end
            end
            if (r_state == S_WAIT) begin
                r_result <= bus.alu_out;
                r_zero   <= bus.alu_zero;
                r_err    <= 1'b0;
            end
        end
    end

    assign bus.done0   = (r_state == S_DONE) && !r_gnt;
    assign bus.done1   = (r_state == S_DONE) &&  r_gnt;
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.result  = r_result;
    assign bus.zero    = r_zero;
    assign bus.err     = r_err;
    assign bus.alu_in1 = r_alu_in1;
    assign bus.alu_in2 = r_alu_in2;
    assign bus.alu_op  = r_alu_op;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: a countdown-based transaction model predicts
// every output each cycle, and directed requests are pinned with literal
// expectations.
`timescale 1ns/1ps
module tb_alu_arbiter;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    alu_arbiter_if #(.WIDTH(W), .OPW(3)) bus ();

    alu_arbiter #(.WIDTH(W), .OPW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ALU operation set: add, sub, and, or, sll, srl, slt.
    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [2:0] op);
        case (op)
            3'd0:    return x + y;
            3'd1:    return x - y;
            3'd2:    return x & y;
            3'd3:    return x | y;
            3'd4:    return x << y[4:0];
            3'd5:    return x >> y[4:0];
            3'd6:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: return '0;
        endcase
    endfunction

    // The shared ALU: one-cycle registered result and equality flag.
    always @(posedge clk) begin
        bus.alu_out  <= alu_fn(bus.alu_in1, bus.alu_in2, bus.alu_op);
        bus.alu_zero <= (bus.alu_in1 == bus.alu_in2);
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Transaction model. m_left counts the busy cycles still to come for the
    // current operation: 3 for a legal op, 1 for an illegal one; the last of
    // them is the done cycle.
    int           m_left;
    logic         m_last;
    logic         m_gnt;
    logic [W-1:0] m_in1, m_in2, m_result, m_pend_result;
    logic [2:0]   m_op;
    logic         m_zero, m_err, m_pend_zero;

    always @(posedge clk or posedge rst) begin
        logic         w;
        logic [W-1:0] a, b;
        logic [2:0]   op;
        if (rst) begin
            m_left = 0; m_last = 1'b1; m_gnt = 1'b0;
            m_in1 = '0; m_in2 = '0; m_op = '0;
            m_result = '0; m_zero = 1'b0; m_err = 1'b0;
            m_pend_result = '0; m_pend_zero = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 1) begin
                m_result = m_pend_result;
                m_zero   = m_pend_zero;
                m_err    = 1'b0;
            end
        end else if (bus.req0 || bus.req1) begin
            w  = (bus.req0 && bus.req1) ? ~m_last : bus.req1;
            m_last = w;
            m_gnt  = w;
            a  = w ? bus.a1  : bus.a0;
            b  = w ? bus.b1  : bus.b0;
            op = w ? bus.op1 : bus.op0;
            if (op == 3'd7) begin
                m_left = 1; m_result = '0; m_zero = 1'b0; m_err = 1'b1;
            end else begin
                m_in1 = a; m_in2 = b; m_op = op;
                m_pend_result = alu_fn(a, b, op);
                m_pend_zero   = (a == b);
                m_left = 3;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("done0",   W'(bus.done0), W'(m_left == 1 && m_gnt == 1'b0));
            chk("done1",   W'(bus.done1), W'(m_left == 1 && m_gnt == 1'b1));
            chk("busy",    W'(bus.busy),  W'(m_left > 0));
            chk("result",  bus.result,    m_result);
            chk("zero",    W'(bus.zero),  W'(m_zero));
            chk("err",     W'(bus.err),   W'(m_err));
            chk("alu_in1", bus.alu_in1,   m_in1);
            chk("alu_in2", bus.alu_in2,   m_in2);
            chk("alu_op",  W'(bus.alu_op), W'(m_op));
        end
    end

    // Raise one request, wait (bounded) for its done, report what was seen.
    task automatic run_req(input bit who, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] op, output logic [W-1:0] res,
                           output logic z, output logic e, output int busy_cyc,
                           output bit other_done);
        bit ok;
        ok = 0; busy_cyc = 0; other_done = 0; res = '0; z = 0; e = 0;
        if (who) begin bus.a1 = a; bus.b1 = b; bus.op1 = op; bus.req1 = 1'b1; end
        else     begin bus.a0 = a; bus.b0 = b; bus.op0 = op; bus.req0 = 1'b1; end
        for (int c = 0; c < 20 && !ok; c++) begin
            @(posedge clk); #1;
            if (bus.busy) busy_cyc++;
            if ((who ? bus.done0 : bus.done1) === 1'b1) other_done = 1;
            if ((who ? bus.done1 : bus.done0) === 1'b1) begin
                ok = 1; res = bus.result; z = bus.zero; e = bus.err;
            end
        end
        if (!ok) chk("done_timeout", 32'd0, 32'd1);
        // Dropped during the done cycle, which never samples requests.
        if (who) bus.req1 = 1'b0; else bus.req0 = 1'b0;
        $display("[TB] req%0d a=%0d b=%0d op=%0d -> result=%0d zero=%0d err=%0d busy=%0d",
                 who, a, b, op, res, z, e, busy_cyc);
    endtask

    logic [W-1:0] res;
    logic         z, e;
    int           bc;
    bit           od;
    bit           order[4];
    logic [W-1:0] dres[4];
    int           k;

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1;
        bus.req0 = 0; bus.a0 = '0; bus.b0 = '0; bus.op0 = '0;
        bus.req1 = 0; bus.a1 = '0; bus.b1 = '0; bus.op1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   W'(bus.busy), 32'd0);
        chk("rst_done",   W'({bus.done1, bus.done0}), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_alu_in", bus.alu_in1 | bus.alu_in2 | W'(bus.alu_op), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // req0 alone: 10 + 5
        run_req(0, 32'd10, 32'd5, 3'd0, res, z, e, bc, od);
        chk("t1_result", res, 32'd15);
        chk("t1_zero",   W'(z), 32'd0);
        chk("t1_err",    W'(e), 32'd0);
        chk("t1_no_done1", W'(od), 32'd0);
        chk("t1_alu_in1", bus.alu_in1, 32'd10);
        chk("t1_alu_in2", bus.alu_in2, 32'd5);
        chk("t1_alu_op",  W'(bus.alu_op), 32'd0);

        // req1 alone: 5 - 5, zero flag set, busy exactly three cycles
        run_req(1, 32'd5, 32'd5, 3'd1, res, z, e, bc, od);
        chk("t2_result", res, 32'd0);
        chk("t2_zero",   W'(z), 32'd1);
        chk("t2_busy_cycles", W'(bc), 32'd3);
        @(posedge clk); #1;
        chk("t2_idle_after", W'(bus.busy), 32'd0);

        // Both held: grants must alternate 0,1,0,1
        bus.a0 = 32'd10; bus.b0 = 32'd5; bus.op0 = 3'd2;
        bus.a1 = 32'd10; bus.b1 = 32'd5; bus.op1 = 3'd3;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        k = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            @(posedge clk); #1;
            if (bus.done0 || bus.done1) begin
                order[k] = bus.done1; dres[k] = bus.result;
                $display("[TB] dual op %0d: granted req%0d result=%0d", k, bus.done1, bus.result);
                k++;
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        chk("t3_count", W'(k), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_order%0d", i), W'(order[i]), W'(i % 2));
            chk($sformatf("t3_result%0d", i), dres[i], (i % 2) ? 32'd15 : 32'd0);
        end

        // Illegal opcode: completes on the cycle after the grant, ALU port untouched
        run_req(0, 32'd9, 32'd9, 3'd7, res, z, e, bc, od);
        chk("t4_err",    W'(e), 32'd1);
        chk("t4_result", res, 32'd0);
        chk("t4_zero",   W'(z), 32'd0);
        chk("t4_busy_cycles", W'(bc), 32'd1);
        chk("t4_alu_op", W'(bus.alu_op), 32'd3);

        // slt then srl
        run_req(0, 32'd1, 32'd5, 3'd6, res, z, e, bc, od);
        chk("t5_slt", res, 32'd1);
        chk("t5_err_cleared", W'(e), 32'd0);
        run_req(0, 32'd16, 32'd2, 3'd5, res, z, e, bc, od);
        chk("t5_srl", res, 32'd4);

        // Reset while waiting on the ALU aborts the operation
        @(posedge clk); #1;
        bus.a0 = 32'd3; bus.b0 = 32'd4; bus.op0 = 3'd0; bus.req0 = 1'b1;
        @(posedge clk);  // grant
        @(posedge clk);  // into the wait phase
        #2;
        chk("t6_busy_before_rst", W'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_busy",   W'(bus.busy), 32'd0);
        chk("t6_done",   W'({bus.done1, bus.done0}), 32'd0);
        chk("t6_result", bus.result, 32'd0);
        chk("t6_alu_in", bus.alu_in1 | bus.alu_in2 | W'(bus.alu_op), 32'd0);
        bus.req0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_no_done_in_rst", W'({bus.done1, bus.done0}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_req(1, 32'd7, 32'd1, 3'd4, res, z, e, bc, od);
        chk("t6_sll", res, 32'd14);
        chk("t6_no_done0", W'(od), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
